// File: rtl/battleship_board_ctrl.sv
// Game-logic writer for the NxN Battleship board: wrapping cursor, ship placement, firing, win/lose.
// Optional cursor blink overlay on the display plane is built when CURSOR_BLINK_EN is defined.
module battleship_board_ctrl #(
  parameter int N         = 5,
  parameter int SHIPS     = 3,
  parameter int MAX_SHOTS = 10,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_sel,
  input  logic                  btn_start,
  output logic [N-1:0][N-1:0]   matrix,
  output logic [N-1:0][N-1:0]   miss_matrix,
  output logic [2:0]            cursor_row,
  output logic [2:0]            cursor_col,
  output logic [1:0]            phase,
  output logic [2:0]            hits,
  output logic [3:0]            shots
);

  typedef enum logic [1:0] {
    PH_PLACE = 2'b00,
    PH_FIRE  = 2'b01,
    PH_WIN   = 2'b10,
    PH_LOSE  = 2'b11
  } phase_e;

  phase_e               phase_q, phase_d;
  logic [N-1:0][N-1:0]  ship_map_q, ship_map_d;
  logic [N-1:0][N-1:0]  shot_map_q, shot_map_d;
  logic [N-1:0][N-1:0]  matrix_q, matrix_d;
  logic [N-1:0][N-1:0]  miss_q, miss_d;
  logic [2:0]           row_q, row_d;
  logic [2:0]           col_q, col_d;
  logic [2:0]           placed_q, placed_d;
  logic [2:0]           hits_q, hits_d;
  logic [3:0]           shots_q, shots_d;

  logic [2:0]           row_mv, col_mv;
  logic [2:0]           hits_n;
  logic [3:0]           shots_n;
  logic                 blink_d;

  // Opposing pulses cancel; row and col wrap independently.
  always_comb begin
    row_mv = row_q;
    col_mv = col_q;
    if (btn_up && !btn_down)
      row_mv = (row_q == 3'd0) ? 3'(N-1) : row_q - 3'd1;
    else if (btn_down && !btn_up)
      row_mv = (row_q == 3'(N-1)) ? 3'd0 : row_q + 3'd1;
    if (btn_left && !btn_right)
      col_mv = (col_q == 3'd0) ? 3'(N-1) : col_q - 3'd1;
    else if (btn_right && !btn_left)
      col_mv = (col_q == 3'(N-1)) ? 3'd0 : col_q + 3'd1;
  end

  // Next-state: sel always uses the pre-move cursor (row_q/col_q).
  always_comb begin
    phase_d    = phase_q;
    ship_map_d = ship_map_q;
    shot_map_d = shot_map_q;
    row_d      = row_q;
    col_d      = col_q;
    placed_d   = placed_q;
    hits_d     = hits_q;
    shots_d    = shots_q;
    hits_n     = hits_q;
    shots_n    = shots_q;

    case (phase_q)
      PH_PLACE: begin
        row_d = row_mv;
        col_d = col_mv;
        if (btn_sel && !ship_map_q[row_q][col_q]) begin
          ship_map_d[row_q][col_q] = 1'b1;
          placed_d = placed_q + 3'd1;
          if (placed_q == 3'(SHIPS-1)) begin
            phase_d = PH_FIRE;
            row_d   = 3'd0;
            col_d   = 3'd0;
          end
        end
      end
      PH_FIRE: begin
        row_d = row_mv;
        col_d = col_mv;
        if (btn_sel && !shot_map_q[row_q][col_q]) begin
          shot_map_d[row_q][col_q] = 1'b1;
          shots_n = shots_q + 4'd1;
          hits_n  = ship_map_q[row_q][col_q] ? hits_q + 3'd1 : hits_q;
          shots_d = shots_n;
          hits_d  = hits_n;
          // A last shot that also sinks the last ship counts as a win.
          if (hits_n == 3'(SHIPS))
            phase_d = PH_WIN;
          else if (shots_n == 4'(MAX_SHOTS))
            phase_d = PH_LOSE;
        end
      end
      default: begin
        if (btn_start) begin
          phase_d    = PH_PLACE;
          ship_map_d = '0;
          shot_map_d = '0;
          row_d      = 3'd0;
          col_d      = 3'd0;
          placed_d   = 3'd0;
          hits_d     = 3'd0;
          shots_d    = 3'd0;
        end
      end
    endcase
  end

  // Display planes are computed from next state so they register alongside it.
  always_comb begin
    if (phase_d == PH_PLACE) begin
      matrix_d = ship_map_d;
      miss_d   = '0;
    end else begin
      matrix_d = ship_map_d & shot_map_d;
      miss_d   = shot_map_d & ~ship_map_d;
    end
    if (phase_d == PH_PLACE || phase_d == PH_FIRE) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (row_d == 3'(r) && col_d == 3'(c))
            matrix_d[r][c] = matrix_d[r][c] ^ blink_d;
        end
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`else
  assign blink_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_PLACE;
      ship_map_q <= '0;
      shot_map_q <= '0;
      matrix_q   <= '0;
      miss_q     <= '0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      placed_q   <= 3'd0;
      hits_q     <= 3'd0;
      shots_q    <= 4'd0;
    end else begin
      phase_q    <= phase_d;
      ship_map_q <= ship_map_d;
      shot_map_q <= shot_map_d;
      matrix_q   <= matrix_d;
      miss_q     <= miss_d;
      row_q      <= row_d;
      col_q      <= col_d;
      placed_q   <= placed_d;
      hits_q     <= hits_d;
      shots_q    <= shots_d;
    end
  end

  assign matrix      = matrix_q;
  assign miss_matrix = miss_q;
  assign cursor_row  = row_q;
  assign cursor_col  = col_q;
  assign phase       = phase_q;
  assign hits        = hits_q;
  assign shots       = shots_q;

endmodule

// File: doc/battleship_board_ctrl.md
Name: battleship_board_ctrl

Overview:
- Game-logic writer for the 5x5 Battleship board; produces the packed `matrix` bus consumed by the VGA display block.
- Takes single-cycle button pulses and moves a wrapping cursor.
- Runs a ship-placement phase, then a firing phase, and reports win/lose.
- Sits between the button debouncers and the display inside the Battleship top.

Parameters:
- N, 5, grid dimension (rows = cols = N); `matrix` is [N-1:0][N-1:0].
- SHIPS, 3, number of single-cell ships placed before firing starts.
- MAX_SHOTS, 10, shots allowed before a loss.
- BLINK_DIV, 12_500_000, cursor blink half-period in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_up  input  1  one-cycle pulse, cursor row-1
- btn_down  input  1  one-cycle pulse, cursor row+1
- btn_left  input  1  one-cycle pulse, cursor col-1
- btn_right  input  1  one-cycle pulse, cursor col+1
- btn_sel  input  1  one-cycle pulse, place ship / fire at cursor
- btn_start  input  1  one-cycle pulse, restart from WIN/LOSE
- matrix  output  [N-1:0][N-1:0]  display plane, bit [r][c] = 1 means lit
- miss_matrix  output  [N-1:0][N-1:0]  cells shot that held no ship
- cursor_row  output  3  current cursor row
- cursor_col  output  3  current cursor col
- phase  output  2  00 PLACE, 01 FIRE, 10 WIN, 11 LOSE
- hits  output  3  ships hit so far
- shots  output  4  shots fired so far

Behaviour:
- Reset (async, active-high): all outputs and internal planes cleared; cursor at (0,0); phase = PLACE.
- Internal planes: `ship_map`, `shot_map` (N×N each). All outputs are registered; effects appear one clk after the input pulse.
- Cursor movement:
  - Movement is modulo N: up from row 0 goes to row N-1, right from col N-1 goes to col 0.
  - up+down in the same cycle cancel; left+right cancel. Row and col move independently in the same cycle.
  - Cursor moves in PLACE and FIRE only; it is frozen in WIN and LOSE.
- btn_sel acts on the pre-move cursor when a move pulse coincides.
- PLACE:
  - sel on an empty cell sets `ship_map[r][c]` and increments the placed count.
  - sel on an occupied cell is ignored.
  - When the placed count reaches SHIPS, go to FIRE on the next edge and return the cursor to (0,0).
  - `matrix` = `ship_map`; `miss_matrix` = 0.
- FIRE:
  - sel on a cell already in `shot_map` is ignored; no counters change.
  - Otherwise set `shot_map[r][c]` and shots+1; if `ship_map[r][c]`, also hits+1.
  - `matrix` = `ship_map & shot_map`; `miss_matrix` = `shot_map & ~ship_map`.
  - After an update: hits == SHIPS goes to WIN (takes priority); else shots == MAX_SHOTS goes to LOSE.
  - A final shot that both wins and exhausts shots goes to WIN.
- WIN / LOSE:
  - Outputs hold; all buttons except btn_start are ignored.
  - btn_start clears `ship_map`, `shot_map`, `hits`, `shots` and the placed count, resets the cursor to (0,0), and enters PLACE on the next edge.
  - btn_start is ignored in PLACE and FIRE.
- Counter widths: counters saturate logically at SHIPS / MAX_SHOTS and never wrap; widths are fixed by the port list.
- Reset asserted mid-game clears everything immediately, regardless of clk.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- When defined:
  - A free-running counter toggles a blink flag every BLINK_DIV cycles.
  - In PLACE and FIRE, `matrix[cursor_row][cursor_col]` is XORed with the blink flag so the cursor cell flashes.
  - The counter and flag are cleared by reset. No overlay in WIN/LOSE.
- When undefined: no counter is built and `matrix` is exactly the plane defined above.

Test Plan:
- Reset wrap: after reset, up pulse gives cursor (4,0); left pulse gives (4,4); right gives (4,0); up+down in the same cycle leaves the cursor unchanged.
- Placement:
  - sel at (0,0), sel at (0,0) again, then right, sel, then right, sel.
  - Required: `matrix` bits [0][0], [0][1], [0][2] set; the duplicate is ignored.
  - phase = FIRE one cycle after the third valid sel; cursor (0,0); `matrix` = 0.
- Win: fire at (0,0), (0,1), (0,2), expect hits 1→2→3, shots = 3; phase = WIN; `matrix` has the three bits set; `miss_matrix` = 0.
- Repeat and miss:
  - In FIRE, sel (1,1) twice: shots = 1, `miss_matrix[1][1]` = 1; the second sel leaves shots unchanged.
  - Then 9 further misses on distinct cells: phase = LOSE at shots = 10.
- Restart and reset:
  - btn_start in LOSE gives phase PLACE with all maps and counters at 0; btn_start in FIRE has no effect.
  - Asserting reset between clk edges mid-FIRE clears outputs asynchronously.
- With CURSOR_BLINK_EN and BLINK_DIV = 4: in PLACE with an empty board, `matrix[0][0]` toggles every 4 cycles; no toggling in WIN.
